// File: rtl/exunit_custom_pipe.sv
// Custom execution unit: single-cycle ALU feeding a fixed-latency shift-register
// pipe with speculative kill/resolve, completing LATENCY cycles after issue.
module exunit_custom_pipe #(
  parameter int DATA_LEN    = 32,
  parameter int SPECTAG_LEN = 5,
  parameter int TAG_W       = 6,
  parameter int LATENCY     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_LEN-1:0]    ex_src1,
  input  logic [DATA_LEN-1:0]    ex_src2,
  input  logic [DATA_LEN-1:0]    imm,
  input  logic                   use_imm,
  input  logic [2:0]             funct3,
  input  logic                   dstval,
  input  logic [TAG_W-1:0]       rrftag_in,
  input  logic [SPECTAG_LEN-1:0] spectag,
  input  logic                   specbit,
  input  logic                   issue,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] spectagfix,
  output logic [DATA_LEN-1:0]    result,
  output logic [TAG_W-1:0]       rrftag_out,
  output logic                   rob_we,
  output logic                   rrf_we,
  output logic [3:0]             inflight
);

  localparam int SH_W = $clog2(DATA_LEN);

  // Handshake: issue is a valid-only strobe. An op is accepted on every edge
  // where issue=1; there is no ready because the pipe never stalls.

  logic [DATA_LEN-1:0]   opb;
  logic [DATA_LEN-1:0]   alu_res;
  logic [2*DATA_LEN-1:0] rot_dbl;

  always_comb begin
    opb     = use_imm ? imm : ex_src2;
    rot_dbl = {ex_src1, ex_src1} << opb[SH_W-1:0];
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = ex_src1 + opb;
      3'b001:  alu_res = ex_src1 - opb;
      3'b010:  alu_res = ex_src1 & opb;
      3'b011:  alu_res = ex_src1 | opb;
      3'b100:  alu_res = ex_src1 ^ opb;
      3'b101:  alu_res = ($signed(ex_src1) < $signed(opb)) ? ex_src1 : opb;
      3'b110:  alu_res = (ex_src1 > opb) ? ex_src1 : opb;
      default: alu_res = rot_dbl[2*DATA_LEN-1:DATA_LEN];
    endcase
  end

  logic [LATENCY-1:0]     st_v, st_sb, st_dst;
  logic [SPECTAG_LEN-1:0] st_spectag [LATENCY];
  logic [TAG_W-1:0]       st_tag     [LATENCY];
  logic [DATA_LEN-1:0]    st_data    [LATENCY];
  logic [3:0]             cnt_q;

  logic [LATENCY-1:0]     k_v, k_sb, n_v, n_sb, n_dst;
  logic [SPECTAG_LEN-1:0] n_spectag [LATENCY];
  logic [TAG_W-1:0]       n_tag     [LATENCY];
  logic [DATA_LEN-1:0]    n_data    [LATENCY];
  logic [3:0]             n_cnt;
  logic                   issue_match;

  // Kill/resolve are applied to each stage's current contents, then shifted.
  always_comb begin
    issue_match = |(spectag & spectagfix);
    for (int i = 0; i < LATENCY; i++) begin
      k_v[i]  = st_v[i] & ~(prmiss & st_sb[i] & |(st_spectag[i] & spectagfix));
      k_sb[i] = st_sb[i] & ~(prsuccess & ~prmiss & |(st_spectag[i] & spectagfix));
    end
    n_v[0]       = issue & ~(prmiss & specbit & issue_match);
    n_sb[0]      = specbit & ~(prsuccess & ~prmiss & issue_match);
    n_dst[0]     = dstval;
    n_spectag[0] = spectag;
    n_tag[0]     = rrftag_in;
    n_data[0]    = alu_res;
    for (int i = 1; i < LATENCY; i++) begin
      n_v[i]       = k_v[i-1];
      n_sb[i]      = k_sb[i-1];
      n_dst[i]     = st_dst[i-1];
      n_spectag[i] = st_spectag[i-1];
      n_tag[i]     = st_tag[i-1];
      n_data[i]    = st_data[i-1];
    end
    n_cnt = '0;
    for (int i = 0; i < LATENCY; i++) n_cnt = n_cnt + 4'(n_v[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_v   <= '0;
      st_sb  <= '0;
      st_dst <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        st_spectag[i] <= '0;
        st_tag[i]     <= '0;
        st_data[i]    <= '0;
      end
    end else begin
      st_v   <= n_v;
      st_sb  <= n_sb;
      st_dst <= n_dst;
      cnt_q  <= n_cnt;
      for (int i = 0; i < LATENCY; i++) begin
        st_spectag[i] <= n_spectag[i];
        st_tag[i]     <= n_tag[i];
        st_data[i]    <= n_data[i];
      end
    end
  end

  // A last-stage op killed this cycle still completes; the kill only drops it.
  assign rob_we     = st_v[LATENCY-1];
  assign rrf_we     = st_v[LATENCY-1] & st_dst[LATENCY-1];
  assign result     = st_data[LATENCY-1];
  assign rrftag_out = st_tag[LATENCY-1];
  assign inflight   = cnt_q;

  logic unused_tail;
  assign unused_tail = ^{k_v[LATENCY-1], k_sb[LATENCY-1], rot_dbl[DATA_LEN-1:0]};

endmodule

// File: tb/tb_exunit_custom_pipe.sv
// Bench for exunit_custom_pipe: vector table plus hand sequences for
// speculation kill/resolve and reset, checked against a due-cycle queue.
module tb_exunit_custom_pipe;

  localparam int LAT = 3;
  localparam int W   = 55;  // {due[15:0], dst, tag[5:0], data[31:0]}

  logic        clk, reset;
  logic [31:0] ex_src1, ex_src2, imm;
  logic        use_imm, dstval, specbit, issue, prmiss, prsuccess;
  logic [2:0]  funct3;
  logic [5:0]  rrftag_in;
  logic [4:0]  spectag, spectagfix;
  logic [31:0] result;
  logic [5:0]  rrftag_out;
  logic        rob_we, rrf_we;
  logic [3:0]  inflight;

  exunit_custom_pipe #(.DATA_LEN(32), .SPECTAG_LEN(5), .TAG_W(6), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .ex_src1(ex_src1), .ex_src2(ex_src2), .imm(imm),
    .use_imm(use_imm), .funct3(funct3), .dstval(dstval), .rrftag_in(rrftag_in),
    .spectag(spectag), .specbit(specbit), .issue(issue), .prmiss(prmiss),
    .prsuccess(prsuccess), .spectagfix(spectagfix), .result(result),
    .rrftag_out(rrftag_out), .rob_we(rob_we), .rrf_we(rrf_we), .inflight(inflight)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int n;
    int due;
    if (mon_en) begin
      n = 0;
      foreach (exp_q[k]) begin
        due = int'(exp_q[k][54:39]);
        if (due - LAT + 1 <= cyc && cyc <= due) n++;
      end
      chk("inflight", 64'(inflight), 64'(n));
      if (exp_q.size() > 0 && int'(exp_q[0][54:39]) <= cyc) begin
        chk("rob_we", 64'(rob_we), 64'd1);
        chk("rrf_we", 64'(rrf_we), 64'(exp_q[0][38]));
        chk("rrftag_out", 64'(rrftag_out), 64'(exp_q[0][37:32]));
        chk("result", 64'(result), 64'(exp_q[0][31:0]));
        void'(exp_q.pop_front());
      end else begin
        chk("rob_we_idle", 64'(rob_we), 64'd0);
        chk("rrf_we_idle", 64'(rrf_we), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue = 0; prmiss = 0; prsuccess = 0; spectagfix = '0;
    specbit = 0; spectag = '0; use_imm = 0; dstval = 0; funct3 = '0;
    rrftag_in = '0; ex_src1 = '0; ex_src2 = '0; imm = '0;
  endtask

  task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic ui, input logic dst, input logic [5:0] tg,
                          input logic sb, input logic [4:0] st,
                          input logic [31:0] exp, input bit track);
    issue = 1; funct3 = f3; ex_src1 = a; use_imm = ui; dstval = dst;
    rrftag_in = tg; specbit = sb; spectag = st;
    if (ui) begin imm = b; ex_src2 = $urandom; end
    else begin ex_src2 = b; imm = $urandom; end
    if (track) exp_q.push_back({16'(cyc + LAT), dst, tg, exp});
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (LAT + 1) step();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        ui;
    logic        dst;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{3'b001, 32'd3,         32'd5,         1'b0, 1'b1, 6'd1,  32'hFFFFFFFE};
    vecs[1]  = '{3'b111, 32'h80000001,  32'd1,         1'b0, 1'b1, 6'd2,  32'h00000003};
    vecs[2]  = '{3'b101, 32'hFFFFFFFE,  32'd1,         1'b0, 1'b1, 6'd3,  32'hFFFFFFFE};
    vecs[3]  = '{3'b000, 32'hFFFFFFFF,  32'd2,         1'b0, 1'b1, 6'd4,  32'h00000001};
    vecs[4]  = '{3'b010, 32'hF0F0F0F0,  32'h0FF00FF0,  1'b0, 1'b1, 6'd5,  32'h00F000F0};
    vecs[5]  = '{3'b011, 32'hF0000000,  32'h0000000F,  1'b1, 1'b1, 6'd6,  32'hF000000F};
    vecs[6]  = '{3'b100, 32'hAAAAAAAA,  32'hFFFF0000,  1'b0, 1'b0, 6'd7,  32'h5555AAAA};
    vecs[7]  = '{3'b110, 32'h7FFFFFFF,  32'h80000000,  1'b0, 1'b1, 6'd8,  32'h80000000};
    vecs[8]  = '{3'b101, 32'h7FFFFFFF,  32'h80000000,  1'b0, 1'b1, 6'd10, 32'h80000000};
    vecs[9]  = '{3'b110, 32'd3,         32'd2,         1'b1, 1'b1, 6'd11, 32'd3};
    vecs[10] = '{3'b111, 32'h12345678,  32'h00000024,  1'b1, 1'b1, 6'd12, 32'h23456781};
    vecs[11] = '{3'b111, 32'h80000000,  32'd31,        1'b0, 1'b1, 6'd13, 32'h40000000};
    vecs[12] = '{3'b001, 32'd10,        32'd3,         1'b1, 1'b0, 6'd14, 32'd7};
    vecs[13] = '{3'b111, 32'hDEADBEEF,  32'd0,         1'b0, 1'b1, 6'd63, 32'hDEADBEEF};
  end

  // ---------------- test ----------------
  initial begin
    clear_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rob_we", 64'(rob_we), 64'd0);
    chk("reset_rrf_we", 64'(rrf_we), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_rrftag", 64'(rrftag_out), 64'd0);
    chk("reset_inflight", 64'(inflight), 64'd0);
    step();
    reset = 1'b1;
    mon_en = 1'b1;

    // ADD 5+7 issued on the first edge after reset release
    issue_op(3'b000, 32'd5, 32'd7, 1'b0, 1'b1, 6'd9, 1'b0, 5'd0, 32'd12, 1'b1);
    step();
    clear_inputs();
    drain();

    // back-to-back vector table
    for (int i = 0; i < 14; i++) begin
      issue_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].ui, vecs[i].dst,
               vecs[i].tag, 1'b0, 5'd0, vecs[i].exp, 1'b1);
      step();
    end
    clear_inputs();
    drain();

    // prmiss kills a speculative op mid-pipe; a non-speculative one survives
    issue_op(3'b000, 32'd1, 32'd1, 1'b0, 1'b1, 6'd20, 1'b1, 5'b00010, 32'd2, 1'b1);
    step();
    issue_op(3'b000, 32'd2, 32'd2, 1'b0, 1'b1, 6'd21, 1'b0, 5'b00010, 32'd4, 1'b1);
    step();
    clear_inputs();
    prmiss = 1; spectagfix = 5'b00010;
    step();
    void'(exp_q.pop_front());
    clear_inputs();
    drain();

    // prsuccess resolves the op before a later prmiss on the same tag
    issue_op(3'b100, 32'hFF, 32'h0F, 1'b0, 1'b1, 6'd22, 1'b1, 5'b00100, 32'hF0, 1'b1);
    step();
    clear_inputs();
    prsuccess = 1; spectagfix = 5'b00100;
    step();
    clear_inputs();
    prmiss = 1; spectagfix = 5'b00100;
    step();
    clear_inputs();
    drain();

    // op issued during a matching prsuccess enters resolved
    issue_op(3'b011, 32'h10, 32'h01, 1'b0, 1'b1, 6'd23, 1'b1, 5'b01000, 32'h11, 1'b1);
    prsuccess = 1; spectagfix = 5'b01000;
    step();
    clear_inputs();
    prmiss = 1; spectagfix = 5'b01000;
    step();
    clear_inputs();
    drain();

    // kill arriving while the op sits in the last stage does not suppress rob_we
    issue_op(3'b000, 32'd100, 32'd23, 1'b0, 1'b1, 6'd24, 1'b1, 5'b00001, 32'd123, 1'b1);
    step();
    clear_inputs();
    step();
    step();
    prmiss = 1; spectagfix = 5'b00001;
    step();
    clear_inputs();
    drain();

    // issue colliding with prmiss (and prsuccess) never enters
    issue_op(3'b000, 32'd9, 32'd9, 1'b0, 1'b1, 6'd25, 1'b1, 5'b00010, 32'd18, 1'b0);
    prmiss = 1; prsuccess = 1; spectagfix = 5'b00010;
    step();
    clear_inputs();
    drain();

    // asynchronous reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      issue_op(3'b000, 32'(i), 32'd1, 1'b0, 1'b1, 6'(30 + i), 1'b0, 5'd0, 32'(i + 1), 1'b1);
      step();
    end
    clear_inputs();
    exp_q.delete();
    #1;
    reset = 1'b0;
    #1;
    chk("async_rob_we", 64'(rob_we), 64'd0);
    chk("async_rrf_we", 64'(rrf_we), 64'd0);
    chk("async_result", 64'(result), 64'd0);
    chk("async_rrftag", 64'(rrftag_out), 64'd0);
    chk("async_inflight", 64'(inflight), 64'd0);
    step();
    step();
    reset = 1'b1;
    repeat (LAT + 3) step();

    chk("final_queue", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exunit_custom_pipe.md
EXUNIT_CUSTOM_PIPE -- requirements
Module: exunit_custom_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_LEN, 32, operand/result width.
- SPECTAG_LEN, 5, speculation tag width, one-hot.
- TAG_W, 6, destination rename tag width.
- LATENCY, 3, issue-to-writeback cycles, legal 1..8.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- ex_src1, in, DATA_LEN, operand A.
- ex_src2, in, DATA_LEN, operand B when use_imm=0.
- imm, in, DATA_LEN, operand B when use_imm=1.
- use_imm, in, 1, operand B select.
- funct3, in, 3, operation select.
- dstval, in, 1, instruction writes a register.
- rrftag_in, in, TAG_W, destination tag.
- spectag, in, SPECTAG_LEN, speculation tag of the issued op.
- specbit, in, 1, issued op is speculative.
- issue, in, 1, op valid this cycle.
- prmiss, in, 1, branch mispredict on spectagfix.
- prsuccess, in, 1, branch resolved correct on spectagfix.
- spectagfix, in, SPECTAG_LEN, resolving branch tag.
- result, out, DATA_LEN, final-stage result.
- rrftag_out, out, TAG_W, final-stage tag.
- rob_we, out, 1, completion strobe.
- rrf_we, out, 1, register-file write strobe.
- inflight, out, 4, count of valid ops in the pipe.

Function
REQ-003 Operand B SHALL be imm when use_imm=1, else ex_src2.
REQ-004 funct3 SHALL select the operation as follows:
- 000 ADD; 001 SUB (A-B); 010 AND; 011 OR; 100 XOR.
- 101 signed MIN; 110 unsigned MAX.
- 111 rotate A left by B[log2(DATA_LEN)-1:0].
- Arithmetic SHALL be modulo 2^DATA_LEN, with carries discarded.
REQ-005 The op SHALL be computed combinationally at issue and captured in stage 1; stages 1..LATENCY SHALL form a shift register of {valid, specbit, spectag, dstval, tag, data}.
REQ-006 An op issued at cycle N SHALL produce rob_we=1 for exactly one cycle at N+LATENCY; with LATENCY=1 this is the next cycle.
REQ-007 rob_we SHALL equal the last-stage valid; rrf_we SHALL equal rob_we & last-stage dstval; result and rrftag_out SHALL be the last-stage fields.
REQ-008 The pipe SHALL accept one issue per cycle, with no backpressure and no structural stall.
REQ-009 Kill: when prmiss=1, every stage with specbit=1 and (spectag & spectagfix)!=0 SHALL have its valid cleared at that clock edge, before it advances.
REQ-010 An op issuing in the same cycle as a matching prmiss SHALL NOT enter the pipe.
REQ-011 A killed op at the last stage in the prmiss cycle SHALL still output rob_we that cycle; the kill applies at the edge only.
REQ-012 Resolve: when prsuccess=1, every stage with a matching spectag SHALL clear its specbit. An op issuing that cycle with a matching tag SHALL enter with specbit=0.
REQ-013 If prmiss and prsuccess are both 1, prmiss SHALL take priority and prsuccess SHALL be ignored.
REQ-014 inflight SHALL equal the number of valid stages after the edge's kill and shift are applied, in the range 0..LATENCY.
REQ-015 When valid=0 the data fields MAY hold stale values; outputs other than the strobes are don't-care when rob_we=0.

Reset
REQ-016 reset=0 SHALL asynchronously clear all valid bits, specbits, data and tag fields, so that rob_we=0, rrf_we=0, result=0, rrftag_out=0 and inflight=0.
REQ-017 Deassertion SHALL be synchronised externally; the first issue SHALL be accepted on the first edge with reset=1.
REQ-018 Asserting reset mid-operation SHALL discard all in-flight ops, and none SHALL complete after release.

Verification
REQ-019 With LATENCY=3, issue ADD 5+7, dstval=1, tag=9 at cycle 0 -> at cycle 3: rob_we=1, rrf_we=1, result=12, rrftag_out=9; strobes are 0 on all other cycles.
REQ-020 With back-to-back issues SUB 3-5, ROT 0x80000001 by 1, MIN -2 vs 1 -> results 0xFFFFFFFE, 0x00000003, 0xFFFFFFFE appear on consecutive cycles, with inflight peaking at 3.
REQ-021 Issue a speculative op with tag 00010 at cycle 0 and a non-speculative op at cycle 1; prmiss with spectagfix=00010 at cycle 2 -> only the second op completes at cycle 4, and inflight drops by 1.
REQ-022 Issue a speculative op with tag 00100, then prsuccess on 00100, then prmiss on 00100 one cycle later -> the op is not killed and completes normally.
REQ-023 Issue in the same cycle as a matching prmiss, with prsuccess also asserted -> the op never completes, and inflight stays 0.
REQ-024 Pull reset low with 3 ops in flight -> outputs are 0 immediately without a clock edge, and no rob_we follows release.
